// File: rtl/sd_seq_pkg.sv
// Shared definitions for the SD command sequencer: state encoding, frame
// command bytes, one-byte status reply codes and the default block size.
// Latency: n/a (definitions only). Backpressure: n/a.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_SEED   = 3'd2,
    S_REQ_WR = 3'd3,
    S_WDATA  = 3'd4,
    S_REQ_RD = 3'd5,
    S_RDATA  = 3'd6,
    S_REPLY  = 3'd7
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  // Command bytes that open a frame
  localparam logic [7:0] CMD_WR_UC = 8'h57;  // "W"
  localparam logic [7:0] CMD_WR_LC = 8'h77;  // "w"
  localparam logic [7:0] CMD_RD_UC = 8'h52;  // "R"
  localparam logic [7:0] CMD_RD_LC = 8'h72;  // "r"

  // Status reply codes
  localparam logic [7:0] ST_OK        = 8'h4B;  // "K" operation complete
  localparam logic [7:0] ST_TIMEOUT   = 8'h54;  // "T" card stopped responding
  localparam logic [7:0] ST_FRAME_ERR = 8'h45;  // "E" frame abandoned mid-way
  localparam logic [7:0] ST_UNKNOWN   = 8'h3F;  // "?" unrecognised command byte

  localparam int BLOCK_BYTES_DEF = 512;

  function automatic logic is_wr_cmd(input logic [7:0] b);
    return (b == CMD_WR_UC) || (b == CMD_WR_LC);
  endfunction

  function automatic logic is_rd_cmd(input logic [7:0] b);
    return (b == CMD_RD_UC) || (b == CMD_RD_LC);
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Handshake bundle between the sequencer, the UART RX stream, the SD card
// driver request/data ports and the TX-side status reply port.
// Latency: n/a (wiring only). Backpressure: carried by the *_ACK signals.
// master = the sequencer; slave = UART/card-driver side.
interface sd_cmd_sequencer_if;
  logic        RX_STB;
  logic [7:0]  RX_DAT;
  logic        WR_STB;
  logic [31:0] WR_ADDR;
  logic        WR_ACK;
  logic        WD_STB;
  logic [7:0]  WD_DATA;
  logic        WD_ACK;
  logic        RD_STB;
  logic [31:0] RD_ADDR;
  logic        RD_ACK;
  logic        RES_STB;
  logic        ST_STB;
  logic [7:0]  ST_DAT;
  logic        ST_ACK;
  logic        BUSY;
  logic [7:0]  DROP_CNT;

  modport master (
    input  RX_STB, RX_DAT, WR_ACK, WD_ACK, RD_ACK, RES_STB, ST_ACK,
    output WR_STB, WR_ADDR, WD_STB, WD_DATA, RD_STB, RD_ADDR,
           ST_STB, ST_DAT, BUSY, DROP_CNT
  );

  modport slave (
    output RX_STB, RX_DAT, WR_ACK, WD_ACK, RD_ACK, RES_STB, ST_ACK,
    input  WR_STB, WR_ADDR, WD_STB, WD_DATA, RD_STB, RD_ADDR,
           ST_STB, ST_DAT, BUSY, DROP_CNT
  );
endinterface

// File: rtl/sd_seq_timeout.sv
// Loadable down-counter used as an inactivity watchdog.
// Latency: expire asserts in the cycle where the count has run down to zero
// while running without a restart. Backpressure: none.
// Ports: restart reloads load_val; run enables counting; expire = timed out.
module sd_seq_timeout #(
  parameter int W = 8
) (
  input  logic         CLOCK50,
  input  logic         RESET,
  input  logic         restart,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A restart in the same cycle always wins over expiry, so progress seen
  // on the last allowed cycle still counts as progress.
  assign expire = run && !restart && (cnt == '0);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Parses UART command frames, drives single-block SD write/read requests,
// generates the write payload and returns a one-byte status reply.
// Latency: request strobe the cycle after the last frame byte; status strobe
// the cycle after the completion event. Backpressure: every outgoing strobe
// holds until its ACK; RX bytes arriving while busy are counted and dropped.
// Ports: CLOCK50/RESET (async, active-high) plus the bus master modport.
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter int BLOCK_BYTES  = BLOCK_BYTES_DEF,
  parameter int TIMEOUT_CYC  = 50000000,
  parameter int FRAME_TO_CYC = 5000000
) (
  input logic                 CLOCK50,
  input logic                 RESET,
  sd_cmd_sequencer_if.master  bus
);

  localparam int TMAX = (TIMEOUT_CYC > FRAME_TO_CYC) ? TIMEOUT_CYC : FRAME_TO_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(BLOCK_BYTES + 1);

  localparam logic [TW-1:0] CARD_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_TO_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(BLOCK_BYTES - 1);

  // Inputs from the bus
  logic       rx_stb;
  logic [7:0] rx_dat;
  logic       wr_ack, wd_ack, rd_ack, res_stb, st_ack;

  assign rx_stb  = bus.RX_STB;
  assign rx_dat  = bus.RX_DAT;
  assign wr_ack  = bus.WR_ACK;
  assign wd_ack  = bus.WD_ACK;
  assign rd_ack  = bus.RD_ACK;
  assign res_stb = bus.RES_STB;
  assign st_ack  = bus.ST_ACK;

  // State and registered outputs
  state_t        state;
  op_t           op;
  logic [1:0]    acnt;
  logic [31:0]   addr_sr;
  logic [7:0]    seed;
  logic [IW-1:0] idx;       // payload index in WDATA, result count in RDATA

  logic          wr_stb, wd_stb, rd_stb, st_stb;
  logic [31:0]   wr_addr, rd_addr;
  logic [7:0]    wd_data, st_dat, drop_cnt;

  // Timeout control
  logic          frame_state, card_state, progress, last_addr_rd;
  logic          tmr_restart, tmr_run, tmr_expire, drop_evt;
  logic [TW-1:0] tmr_load_val;

  assign frame_state  = (state == S_ADDR) || (state == S_SEED);
  assign card_state   = (state == S_REQ_WR) || (state == S_WDATA) ||
                        (state == S_REQ_RD) || (state == S_RDATA);
  assign last_addr_rd = (state == S_ADDR) && (acnt == 2'd3) && (op == OP_RD);

  always_comb begin
    progress = 1'b0;
    case (state)
      S_REQ_WR: progress = wr_ack;
      S_WDATA:  progress = wd_ack;
      S_REQ_RD: progress = rd_ack;
      S_RDATA:  progress = res_stb;
      default:  progress = 1'b0;
    endcase
  end

  // The counter is held loaded outside timed states so the first timed
  // state always starts from a full window. The reload value switches to
  // the card window on the byte that completes a frame.
  assign tmr_restart  = (state == S_IDLE) || (state == S_REPLY) ||
                        (frame_state && rx_stb) || (card_state && progress);
  assign tmr_load_val = ((state == S_SEED) || last_addr_rd || card_state) ?
                        CARD_LOAD : FRAME_LOAD;
  assign tmr_run      = frame_state || card_state;

  assign drop_evt = rx_stb && !((state == S_IDLE) || frame_state);

  sd_seq_timeout #(.W(TW)) u_tmr (
    .CLOCK50  (CLOCK50),
    .RESET    (RESET),
    .restart  (tmr_restart),
    .load_val (tmr_load_val),
    .run      (tmr_run),
    .expire   (tmr_expire)
  );

  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      op       <= OP_WR;
      acnt     <= '0;
      addr_sr  <= '0;
      seed     <= '0;
      idx      <= '0;
      wr_stb   <= 1'b0;
      wd_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      st_stb   <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wd_data  <= '0;
      st_dat   <= '0;
      drop_cnt <= '0;
    end else begin
      if (drop_evt && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (rx_stb) begin
            acnt <= '0;
            if (is_wr_cmd(rx_dat)) begin
              op    <= OP_WR;
              state <= S_ADDR;
            end else if (is_rd_cmd(rx_dat)) begin
              op    <= OP_RD;
              state <= S_ADDR;
            end else begin
              st_dat <= ST_UNKNOWN;
              st_stb <= 1'b1;
              state  <= S_REPLY;
            end
          end
        end

        S_ADDR: begin
          if (rx_stb) begin
            addr_sr <= {addr_sr[23:0], rx_dat};
            acnt    <= acnt + 2'd1;
            if (acnt == 2'd3) begin
              if (op == OP_WR) begin
                state <= S_SEED;
              end else begin
                rd_addr <= {addr_sr[23:0], rx_dat};
                rd_stb  <= 1'b1;
                state   <= S_REQ_RD;
              end
            end
          end else if (tmr_expire) begin
            st_dat <= ST_FRAME_ERR;
            st_stb <= 1'b1;
            state  <= S_REPLY;
          end
        end

        S_SEED: begin
          if (rx_stb) begin
            seed    <= rx_dat;
            wr_addr <= addr_sr;
            wr_stb  <= 1'b1;
            state   <= S_REQ_WR;
          end else if (tmr_expire) begin
            st_dat <= ST_FRAME_ERR;
            st_stb <= 1'b1;
            state  <= S_REPLY;
          end
        end

        S_REQ_WR: begin
          if (wr_ack) begin
            wr_stb  <= 1'b0;
            wd_stb  <= 1'b1;
            wd_data <= seed;
            idx     <= '0;
            state   <= S_WDATA;
          end else if (tmr_expire) begin
            wr_stb <= 1'b0;
            st_dat <= ST_TIMEOUT;
            st_stb <= 1'b1;
            state  <= S_REPLY;
          end
        end

        S_WDATA: begin
          if (wd_ack) begin
            if (idx == LAST_IDX) begin
              wd_stb <= 1'b0;
              st_dat <= ST_OK;
              st_stb <= 1'b1;
              state  <= S_REPLY;
            end else begin
              idx     <= idx + IW'(1);
              wd_data <= wd_data + 8'd1;  // wraps modulo 256
            end
          end else if (tmr_expire) begin
            wd_stb <= 1'b0;
            st_dat <= ST_TIMEOUT;
            st_stb <= 1'b1;
            state  <= S_REPLY;
          end
        end

        S_REQ_RD: begin
          if (rd_ack) begin
            rd_stb <= 1'b0;
            idx    <= '0;
            state  <= S_RDATA;
          end else if (tmr_expire) begin
            rd_stb <= 1'b0;
            st_dat <= ST_TIMEOUT;
            st_stb <= 1'b1;
            state  <= S_REPLY;
          end
        end

        S_RDATA: begin
          if (res_stb) begin
            if (idx == LAST_IDX) begin
              st_dat <= ST_OK;
              st_stb <= 1'b1;
              state  <= S_REPLY;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (tmr_expire) begin
            st_dat <= ST_TIMEOUT;
            st_stb <= 1'b1;
            state  <= S_REPLY;
          end
        end

        S_REPLY: begin
          if (st_ack) begin
            st_stb <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.WR_STB   = wr_stb;
  assign bus.WR_ADDR  = wr_addr;
  assign bus.WD_STB   = wd_stb;
  assign bus.WD_DATA  = wd_data;
  assign bus.RD_STB   = rd_stb;
  assign bus.RD_ADDR  = rd_addr;
  assign bus.ST_STB   = st_stb;
  assign bus.ST_DAT   = st_dat;
  assign bus.BUSY     = (state != S_IDLE);
  assign bus.DROP_CNT = drop_cnt;

endmodule
